// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared types and helpers for the FPU mantissa datapath.
//   lzc_mode_e  : selects whether leading zeros or leading ones are counted
//   lzc_cnt_w() : width of a count that must be able to hold the value w
// ----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic {
        LZC_ZEROS = 1'b0,
        LZC_ONES  = 1'b1
    } lzc_mode_e;

    function automatic int lzc_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lzc_core.sv
// ----------------------------------------------------------------------------
// lzc_core
// Purely combinational leading-zero counter built as a log2 tree of pairwise
// (valid, count) merges.
//   in   [WIDTH-1:0]  value to scan from the MSB down
//   cnt  [CNT_W-1:0]  number of leading zeros; WIDTH when in is all zeros
//   zero              1 when in is all zeros
// ----------------------------------------------------------------------------
module lzc_core #(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    localparam int LP = $clog2(WIDTH);
    localparam int P  = 1 << LP;

    // The tree works on a power-of-two width. The padding below the real LSB
    // is all ones, so a scan that runs off the end of 'in' stops exactly at
    // position WIDTH.
    logic [P-1:0] pad;

    always_comb begin
        pad = '1;
        pad[P-1 -: WIDTH] = in;
    end

    // Level l node i covers 2**l bits, node 0 being the most significant.
    // v = some 1 seen in the node, c = zeros before the first 1.
    for (genvar l = 0; l <= LP; l++) begin : g_lvl
        localparam int N = P >> l;
        logic [N-1:0]    v;
        logic [N*LP-1:0] c;

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign v[i]           = pad[P-1-i];
                assign c[i*LP +: LP]  = '0;
            end
        end else begin : g_merge
            localparam logic [LP-1:0] HALF = LP'(1 << (l - 1));
            for (genvar i = 0; i < N; i++) begin : g_node
                assign v[i] = g_lvl[l-1].v[2*i] | g_lvl[l-1].v[2*i+1];
                // Upper half wins when it holds a 1; otherwise the whole upper
                // half is zeros and the lower half's count is added on.
                assign c[i*LP +: LP] = g_lvl[l-1].v[2*i]
                                     ? g_lvl[l-1].c[2*i*LP +: LP]
                                     : HALF + g_lvl[l-1].c[(2*i+1)*LP +: LP];
            end
        end
    end

    logic          root_v;
    logic [LP-1:0] root_c;

    assign root_v = g_lvl[LP].v[0];
    assign root_c = g_lvl[LP].c[LP-1:0];

    // root_v can only be 0 when no padding exists (WIDTH is a power of two),
    // in which case P equals WIDTH.
    assign cnt  = root_v ? CNT_W'(root_c) : CNT_W'(P);
    assign zero = ~|in;

endmodule

// File: rtl/lzc_norm_pipe.sv
// ----------------------------------------------------------------------------
// lzc_norm_pipe
// Two-stage pipelined leading-zero/leading-one counter and normaliser.
// Stage 1 registers the data, count and all-flag; stage 2 registers the
// left-shifted mantissa. Valid/ready handshake on both sides.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input beat valid          in_ready : block accepts the beat
//   in_data    : mantissa                  in_mode  : LZC_ZEROS / LZC_ONES
//   in_tag     : sideband, returned unmodified with the result
//   out_valid  : result valid              out_ready: downstream accepts
//   out_count  : leading zeros/ones, WIDTH when no terminating bit exists
//   out_norm   : in_data << out_count, zero-filled
//   out_all    : every bit equals the counted value (count == WIDTH)
//   out_tag    : in_tag of the same beat
// ----------------------------------------------------------------------------
module lzc_norm_pipe
    import fpu_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CNT_W = lzc_cnt_w(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  lzc_mode_e        in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_all,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH-1:0] lzc_in;
    logic [CNT_W-1:0] core_cnt;
    logic             core_zero;

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             all_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [WIDTH-1:0] shifted_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] norm_p2;
    logic [CNT_W-1:0] cnt_p2;
    logic             all_p2;
    logic [TAG_W-1:0] tag_p2;

    // Ready chain: a stage moves when it is empty or the next stage moves.
    // in_ready is therefore combinational from out_ready.
    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;

    // Counting leading ones is counting leading zeros of the complement.
    assign lzc_in = (in_mode == LZC_ONES) ? ~in_data : in_data;

    lzc_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .in   (lzc_in),
        .cnt  (core_cnt),
        .zero (core_zero)
    );

    // ---- stage 1: data, count, all-flag, tag ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            data_p1 <= in_data;
            cnt_p1  <= core_cnt;
            all_p1  <= core_zero;
            tag_p1  <= in_tag;
        end
    end

    // all_p1 is exactly the count == WIDTH case; the result is defined as 0.
    assign shifted_p1 = all_p1 ? '0 : (data_p1 << cnt_p1);

    // ---- stage 2: normalised mantissa and result payload ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            norm_p2 <= '0;
            cnt_p2  <= '0;
            all_p2  <= 1'b0;
            tag_p2  <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                norm_p2 <= shifted_p1;
                cnt_p2  <= cnt_p1;
                all_p2  <= all_p1;
                tag_p2  <= tag_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_norm  = norm_p2;
    assign out_count = cnt_p2;
    assign out_all   = all_p2;
    assign out_tag   = tag_p2;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// ----------------------------------------------------------------------------
// tb_lzc_norm_pipe
// Self-checking bench: three instances (WIDTH 24, 10, 53) share the control
// inputs; directed table vectors on WIDTH 24, hand-written handshake/reset
// sequences, and a scoreboard against a linear-scan model for random traffic.
// ----------------------------------------------------------------------------
module tb_lzc_norm_pipe;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    lzc_mode_e   in_mode = LZC_ZEROS;
    logic [3:0]  in_tag = '0;
    logic [52:0] in_data = '0;

    logic        rdy24, ov24, all24;
    logic [4:0]  cnt24;
    logic [23:0] norm24;
    logic [3:0]  tag24;
    logic        rdy10, ov10, all10;
    logic [3:0]  cnt10;
    logic [9:0]  norm10;
    logic [3:0]  tag10;
    logic        rdy53, ov53, all53;
    logic [5:0]  cnt53;
    logic [52:0] norm53;
    logic [3:0]  tag53;

    always #5 clk = ~clk;

    lzc_norm_pipe #(.WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy24),
        .in_data(in_data[23:0]), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(ov24), .out_ready(out_ready), .out_count(cnt24),
        .out_norm(norm24), .out_all(all24), .out_tag(tag24));

    lzc_norm_pipe #(.WIDTH(10)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy10),
        .in_data(in_data[9:0]), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(ov10), .out_ready(out_ready), .out_count(cnt10),
        .out_norm(norm10), .out_all(all10), .out_tag(tag10));

    lzc_norm_pipe #(.WIDTH(53)) dut53 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy53),
        .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(ov53), .out_ready(out_ready), .out_count(cnt53),
        .out_norm(norm53), .out_all(all53), .out_tag(tag53));

    typedef struct packed {
        logic        mode;
        logic [23:0] data;
        logic [3:0]  tag;
        logic [4:0]  cnt;
        logic [23:0] norm;
        logic        all;
    } vec_t;

    typedef struct packed {
        logic [31:0] cnt;
        logic [63:0] norm;
        logic        all;
        logic [3:0]  tag;
    } exp_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    vec_t tbl [10];
    exp_t q24 [$];
    exp_t q10 [$];
    exp_t q53 [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Linear scan from the MSB: deliberately a different shape from the tree.
    function automatic exp_t model(input logic [63:0] d, input int w, input bit mode,
                                   input logic [3:0] tag);
        exp_t e;
        bit   found = 1'b0;
        e.cnt = 32'(w);
        for (int i = w - 1; i >= 0; i--) begin
            if (!found && (d[i] != mode)) begin
                e.cnt = 32'(w - 1 - i);
                found = 1'b1;
            end
        end
        e.norm = (d << e.cnt) & ((64'd1 << w) - 64'd1);
        e.all  = (e.cnt == 32'(w));
        e.tag  = tag;
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q24.delete();
        q10.delete();
        q53.delete();
    endtask

    task automatic check_reset_state(input string pfx);
        @(negedge clk);
        chk({pfx, "_out_valid"}, 64'(ov24), 64'(0));
        chk({pfx, "_in_ready"},  64'(rdy24), 64'(1));
        chk({pfx, "_count"},     64'(cnt24), 64'(0));
        chk({pfx, "_norm"},      64'(norm24), 64'(0));
        chk({pfx, "_all"},       64'(all24), 64'(0));
        chk({pfx, "_tag"},       64'(tag24), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // One beat through WIDTH 24 with out_ready high; called at posedge+1.
    task automatic apply_vec(input vec_t v);
        in_data   = 53'(v.data);
        in_mode   = lzc_mode_e'(v.mode);
        in_tag    = v.tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("vec_in_ready", 64'(rdy24), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("vec_early_valid", 64'(ov24), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("vec_valid", 64'(ov24),   64'(1));
        chk("vec_count", 64'(cnt24),  64'(v.cnt));
        chk("vec_norm",  64'(norm24), 64'(v.norm));
        chk("vec_all",   64'(all24),  64'(v.all));
        chk("vec_tag",   64'(tag24),  64'(v.tag));
        @(posedge clk);
        #1;
    endtask

    // One cycle of scoreboard traffic; inputs already driven at posedge+1.
    task automatic monitor(output bit acc, output bit ovs);
        exp_t e;
        @(negedge clk);
        ovs = ov24;
        if (ov24 && out_ready) begin
            if (q24.size() == 0) chk("w24_unexpected", 64'(1), 64'(0));
            else begin
                e = q24.pop_front();
                chk("w24_count", 64'(cnt24), 64'(e.cnt));
                chk("w24_norm",  64'(norm24), e.norm);
                chk("w24_all",   64'(all24), 64'(e.all));
                chk("w24_tag",   64'(tag24), 64'(e.tag));
            end
        end
        if (ov10 && out_ready) begin
            if (q10.size() == 0) chk("w10_unexpected", 64'(1), 64'(0));
            else begin
                e = q10.pop_front();
                chk("w10_count", 64'(cnt10), 64'(e.cnt));
                chk("w10_norm",  64'(norm10), e.norm);
                chk("w10_all",   64'(all10), 64'(e.all));
                chk("w10_tag",   64'(tag10), 64'(e.tag));
            end
        end
        if (ov53 && out_ready) begin
            if (q53.size() == 0) chk("w53_unexpected", 64'(1), 64'(0));
            else begin
                e = q53.pop_front();
                chk("w53_count", 64'(cnt53), 64'(e.cnt));
                chk("w53_norm",  64'(norm53), e.norm);
                chk("w53_all",   64'(all53), 64'(e.all));
                chk("w53_tag",   64'(tag53), 64'(e.tag));
            end
        end
        if (in_valid && rdy24) q24.push_back(model(64'(in_data[23:0]), 24, bit'(in_mode), in_tag));
        if (in_valid && rdy10) q10.push_back(model(64'(in_data[9:0]), 10, bit'(in_mode), in_tag));
        if (in_valid && rdy53) q53.push_back(model(64'(in_data), 53, bit'(in_mode), in_tag));
        acc = in_valid && rdy24;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_check(input string pfx);
        bit acc, ovs;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) monitor(acc, ovs);
        chk({pfx, "_left24"}, 64'(q24.size()), 64'(0));
        chk({pfx, "_left10"}, 64'(q10.size()), 64'(0));
        chk({pfx, "_left53"}, 64'(q53.size()), 64'(0));
    endtask

    initial begin
        bit          acc, ovs;
        int          got [$];
        int          done, guard;
        logic [52:0] x;

        tbl[0] = '{1'b0, 24'h000001, 4'h1, 5'd23, 24'h800000, 1'b0};
        tbl[1] = '{1'b0, 24'h800000, 4'h2, 5'd0,  24'h800000, 1'b0};
        tbl[2] = '{1'b0, 24'h000000, 4'h3, 5'd24, 24'h000000, 1'b1};
        tbl[3] = '{1'b1, 24'hFFFFFF, 4'h4, 5'd24, 24'h000000, 1'b1};
        tbl[4] = '{1'b1, 24'hFF0F00, 4'h5, 5'd8,  24'h0F0000, 1'b0};
        tbl[5] = '{1'b0, 24'hFF0F00, 4'h6, 5'd0,  24'hFF0F00, 1'b0};
        tbl[6] = '{1'b0, 24'h00F000, 4'h7, 5'd8,  24'hF00000, 1'b0};
        tbl[7] = '{1'b1, 24'h7FFFFF, 4'h8, 5'd0,  24'h7FFFFF, 1'b0};
        tbl[8] = '{1'b1, 24'hFFFFFE, 4'h9, 5'd23, 24'h000000, 1'b0};
        tbl[9] = '{1'b0, 24'h000003, 4'hA, 5'd22, 24'hC00000, 1'b0};

        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < 10; i++) apply_vec(tbl[i]);

        // Backpressure: two beats buffered, third stalls, order preserved.
        do_reset();
        in_mode  = LZC_ZEROS;
        in_data  = 53'h000001;
        in_tag   = 4'd1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready1", 64'(rdy24), 64'(1));
        @(posedge clk);
        #1 in_tag = 4'd2;
        @(negedge clk);
        chk("bp_ready2", 64'(rdy24), 64'(1));
        @(posedge clk);
        #1 in_tag = 4'd3;
        @(negedge clk);
        chk("bp_ready3", 64'(rdy24), 64'(0));
        chk("bp_valid",  64'(ov24),  64'(1));
        chk("bp_head",   64'(tag24), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_hold_ready", 64'(rdy24), 64'(0));
        chk("bp_hold_tag",   64'(tag24), 64'(1));
        chk("bp_hold_count", 64'(cnt24), 64'(23));
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov24 && out_ready) got.push_back(int'(tag24));
            acc = in_valid && rdy24;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        chk("bp_count_out", 64'(got.size()), 64'(3));
        for (int k = 0; k < 3; k++)
            if (k < got.size()) chk("bp_order", 64'(got[k]), 64'(k + 1));

        // Streaming: 100 back-to-back beats, results on 100 consecutive cycles.
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 105; c++) begin
            in_valid = (c < 100);
            x        = {21'($urandom), 32'($urandom)} >> $urandom_range(0, 53);
            in_data  = x;
            in_mode  = lzc_mode_e'(1'($urandom_range(0, 1)));
            in_tag   = 4'(c);
            monitor(acc, ovs);
            chk("stream_accept", 64'(acc), 64'(c < 100));
            chk("stream_valid",  64'(ovs), 64'((c >= 2) && (c < 102)));
        end
        drain_and_check("stream");

        // Reset with two beats in flight.
        do_reset();
        in_mode  = LZC_ZEROS;
        in_data  = 53'h000001;
        in_tag   = 4'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_tag = 4'd6;
        in_data = 53'h800000;
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("midrst");
        apply_vec(tbl[0]);

        // WIDTH 10 exhaustive, random mode and backpressure on all widths.
        do_reset();
        done  = 0;
        guard = 0;
        while (done < 1024 && guard < 20000) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            x          = {21'($urandom), 32'($urandom)};
            x[9:0]     = 10'(done);
            in_data    = x;
            in_mode    = lzc_mode_e'(1'($urandom_range(0, 1)));
            in_tag     = 4'($urandom);
            monitor(acc, ovs);
            if (acc) done++;
            guard++;
        end
        chk("exh_timeout", 64'(done), 64'(1024));
        drain_and_check("exh");

        // Shaped random data so long runs of zeros/ones are common on WIDTH 53.
        do_reset();
        done  = 0;
        guard = 0;
        while (done < 1500 && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_mode   = lzc_mode_e'(1'($urandom_range(0, 1)));
            x         = {21'($urandom), 32'($urandom)} >> $urandom_range(0, 53);
            in_data   = (in_mode == LZC_ONES) ? ~x : x;
            in_tag    = 4'($urandom);
            monitor(acc, ovs);
            if (acc) done++;
            guard++;
        end
        chk("rand_timeout", 64'(done), 64'(1500));
        drain_and_check("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
